// File: rtl/load_extract_unit_pkg.sv
// Shared definitions for the load extract unit: load type encodings, FSM states,
// lane select width and small decode helpers.
package load_extract_unit_pkg;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam int LANE_SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } state_e;

    function automatic logic is_legal_type(input logic [2:0] t);
        return t <= LT_LBU;
    endfunction

    // Word loads need a word-aligned address, halfword loads a halfword-aligned one.
    function automatic logic is_misaligned(input logic [2:0] t, input logic [LANE_SEL_W-1:0] lo);
        return ((t == LT_LW) && (lo != 2'b00)) ||
               (((t == LT_LH) || (t == LT_LHU)) && lo[0]);
    endfunction

endpackage

// File: rtl/load_extract_unit_lane_extract.sv
// load_lane_extract: combinational lane select plus sign/zero extension of a
// little-endian read word into a 32-bit write-back value.
module load_lane_extract
    import load_extract_unit_pkg::*;
(
    input  logic [31:0]           rdata,
    input  logic [LANE_SEL_W-1:0] lo,
    input  logic [2:0]            ltype,
    output logic [31:0]           word
);

    logic [3:0][7:0] lanes;
    logic [7:0]      byte_f;
    logic [15:0]     half_f;

    assign lanes  = rdata;
    assign byte_f = lanes[lo];
    // Halfword lanes pick by addr[1] only; addr[0] never shifts the field.
    assign half_f = lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        word = rdata;
        case (ltype)
            LT_LH:   word = {{16{half_f[15]}}, half_f};
            LT_LHU:  word = {16'h0000, half_f};
            LT_LB:   word = {{24{byte_f[7]}}, byte_f};
            LT_LBU:  word = {24'h000000, byte_f};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/load_extract_unit.sv
// load_extract_unit: accepts one load, issues a word read, extracts/extends the lane.
// Build option MISALIGN_TRAP_EN: misaligned LW/LH/LHU complete with err instead of reading.
module load_extract_unit
    import load_extract_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              done_valid,
    output logic [31:0]       word,
    output logic              err
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              lat_type;
    logic [LANE_SEL_W-1:0]   lat_lo;
    logic [31:0]             ext_word;
    logic                    accept;
    logic                    reject;

    assign accept = clk_en && req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
    assign reject = !is_legal_type(req_type) || is_misaligned(req_type, req_addr[1:0]);
`else
    assign reject = !is_legal_type(req_type);
`endif

    load_lane_extract u_extract (
        .rdata (mem_rdata),
        .lo    (lat_lo),
        .ltype (lat_type),
        .word  (ext_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            done_valid <= 1'b0;
            word       <= '0;
            err        <= 1'b0;
            cnt        <= '0;
            lat_type   <= LT_LW;
            lat_lo     <= '0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        lat_type  <= req_type;
                        lat_lo    <= req_addr[1:0];
                        cnt       <= '0;
                        if (reject) begin
                            word       <= '0;
                            err        <= 1'b1;
                            done_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_rd   <= 1'b1;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // An ack on the final counted cycle still counts as success.
                    if (mem_ack) begin
                        word       <= ext_word;
                        err        <= 1'b0;
                        done_valid <= 1'b1;
                        mem_rd     <= 1'b0;
                        state      <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        word       <= '0;
                        err        <= 1'b1;
                        done_valid <= 1'b1;
                        mem_rd     <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    mem_rd     <= 1'b0;
                    done_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_extract_unit.sv
// Self-checking bench for load_extract_unit: scoreboarded loads covering extraction,
// ack latency, back-to-back, timeout, illegal/misaligned requests, reset and stall.
module tb_load_extract_unit;

    localparam logic [2:0] T_LW = 3'd0, T_LH = 3'd1, T_LHU = 3'd2, T_LB = 3'd3, T_LBU = 3'd4;
    localparam int NO_ACK = -100;

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_type = '0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h80FF7F01;
    logic        done_valid;
    logic [31:0] word;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    load_extract_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .done_valid (done_valid),
        .word       (word),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference extraction, written as shift-and-mask rather than lane indexing.
    function automatic logic [31:0] ref_extract(input logic [31:0] d, input logic [31:0] a, input logic [2:0] t);
        logic [31:0] sh;
        case (t)
            T_LB:    begin sh = d >> (8 * a[1:0]); return {{24{sh[7]}}, sh[7:0]}; end
            T_LBU:   begin sh = d >> (8 * a[1:0]); return {24'h0, sh[7:0]}; end
            T_LH:    begin sh = d >> (16 * a[1]); return {{16{sh[15]}}, sh[15:0]}; end
            T_LHU:   begin sh = d >> (16 * a[1]); return {16'h0, sh[15:0]}; end
            default: return d;
        endcase
    endfunction

    // Called at a falling edge. Drives one request and plays memory: ack d cycles after
    // mem_rd first rises; during a stall window clk_en is low and mem_ack is held high.
    task automatic do_load(input logic [31:0] a, input logic [2:0] t, input int d, input int stall_at,
                           output logic [31:0] w, output logic e, output int lat, output int rd_cnt,
                           output logic [31:0] ma, output logic rdy0, output logic tail_ok);
        logic stalled;
        rdy0 = req_ready;
        req_valid = 1'b1; req_addr = a; req_type = t;
        lat = -1; rd_cnt = 0; ma = 'x; w = 'x; e = 'x; tail_ok = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (done_valid) begin
                w = word; e = err; lat = i;
                mem_ack = 1'b0; clk_en = 1'b1;
                break;
            end
            if (mem_rd) begin
                rd_cnt++;
                if (rd_cnt == 1) ma = mem_addr;
            end
            stalled = (stall_at > 0) && (i >= stall_at) && (i < stall_at + 5);
            clk_en  = !stalled;
            mem_ack = stalled || (i == 1 + d);
        end
        mem_ack = 1'b0; clk_en = 1'b1;
        if (lat > 0) begin
            @(negedge clk);
            tail_ok = !done_valid && req_ready && !mem_rd;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, mem_rd, mem_addr, done_valid, word, err} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rd=%b addr=%h dv=%b word=%h err=%b, need 1 0 0 0 0 0",
                     req_ready, mem_rd, mem_addr, done_valid, word, err);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_extract();
        logic [31:0] addrs[10] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101, 32'h102, 32'h102};
        logic [2:0]  types[10] = '{T_LB, T_LB, T_LBU, T_LH, T_LHU, T_LH, T_LW, T_LB, T_LB, T_LBU};
        logic [31:0] golden[10] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                    32'h00007F01, 32'h80FF7F01, 32'h0000007F, 32'hFFFFFFFF, 32'h000000FF};
        logic [31:0] w, ma; logic e, rdy, tail; int lat, rdc; exp_t x;
        mem_rdata = 32'h80FF7F01;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back('{word: golden[k], err: 1'b0, lat: 2});
            do_load(addrs[k], types[k], 0, 0, w, e, lat, rdc, ma, rdy, tail);
            x = exp_q.pop_front();
            checks++;
            if (w !== x.word || e !== x.err || lat != x.lat || ma !== 32'h100) begin
                errors++;
                $display("FAIL extract[%0d]: word=%h err=%b lat=%0d addr=%h, need word=%h err=%b lat=%0d addr=00000100",
                         k, w, e, lat, ma, x.word, x.err, x.lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w, ma, a; logic [2:0] t; logic e, rdy, tail; int lat, rdc; exp_t x;
        for (int k = 0; k < 12; k++) begin
            mem_rdata = $urandom;
            a = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(0, 3));
            t = 3'($urandom_range(0, 4));
`ifndef MISALIGN_TRAP_EN
            exp_q.push_back('{word: ref_extract(mem_rdata, a, t), err: 1'b0, lat: 2});
`else
            if ((t == T_LW && a[1:0] != 0) || ((t == T_LH || t == T_LHU) && a[0]))
                exp_q.push_back('{word: 32'h0, err: 1'b1, lat: 1});
            else
                exp_q.push_back('{word: ref_extract(mem_rdata, a, t), err: 1'b0, lat: 2});
`endif
            do_load(a, t, 0, 0, w, e, lat, rdc, ma, rdy, tail);
            x = exp_q.pop_front();
            checks++;
            if (w !== x.word || e !== x.err || lat != x.lat) begin
                errors++;
                $display("FAIL random[%0d] a=%h t=%0d: word=%h err=%b lat=%0d, need word=%h err=%b lat=%0d",
                         k, a, t, w, e, lat, x.word, x.err, x.lat);
            end
        end
        mem_rdata = 32'h80FF7F01;
    endtask

    task automatic test_delayed_ack();
        logic [31:0] w, ma; logic e, rdy, tail; int lat, rdc; exp_t x;
        exp_q.push_back('{word: 32'hFFFFFF80, err: 1'b0, lat: 5});
        do_load(32'h103, T_LB, 3, 0, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat || rdc != 4) begin
            errors++;
            $display("FAIL delayed_ack: word=%h err=%b lat=%0d rd_cycles=%0d, need %h %b %0d 4",
                     w, e, lat, rdc, x.word, x.err, x.lat);
        end
        checks++;
        if (tail !== 1'b1) begin
            errors++;
            $display("FAIL delayed_ack_tail: pulse/ready after result=%b, need 1", tail);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w, ma; logic e, rdy, tail; int lat, rdc; exp_t x;
        exp_q.push_back('{word: 32'h000080FF, err: 1'b0, lat: 3});
        exp_q.push_back('{word: 32'h00007F01, err: 1'b0, lat: 2});
        exp_q.push_back('{word: 32'h80FF7F01, err: 1'b0, lat: 4});
        do_load(32'h102, T_LHU, 1, 0, w, e, lat, rdc, ma, rdy, tail);
        for (int k = 0; k < 3; k++) begin
            x = exp_q.pop_front();
            checks++;
            if (w !== x.word || e !== x.err || lat != x.lat || rdy !== 1'b1 || tail !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: word=%h err=%b lat=%0d ready=%b tail=%b, need %h %b %0d 1 1",
                         k, w, e, lat, rdy, tail, x.word, x.err, x.lat);
            end
            if (k == 0) do_load(32'h100, T_LH, 0, 0, w, e, lat, rdc, ma, rdy, tail);
            if (k == 1) do_load(32'h100, T_LW, 2, 0, w, e, lat, rdc, ma, rdy, tail);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w, ma; logic e, rdy, tail; int lat, rdc; exp_t x;
        exp_q.push_back('{word: 32'h0, err: 1'b1, lat: 17});
        do_load(32'h100, T_LW, NO_ACK, 0, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat || rdc != 16) begin
            errors++;
            $display("FAIL timeout: word=%h err=%b lat=%0d rd_cycles=%0d, need %h %b %0d 16",
                     w, e, lat, rdc, x.word, x.err, x.lat);
        end
        exp_q.push_back('{word: 32'h80FF7F01, err: 1'b0, lat: 17});
        do_load(32'h100, T_LW, 15, 0, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat) begin
            errors++;
            $display("FAIL ack_at_limit: word=%h err=%b lat=%0d, need %h %b %0d", w, e, lat, x.word, x.err, x.lat);
        end
    endtask

    task automatic test_illegal_misalign();
        logic [31:0] w, ma; logic e, rdy, tail; int lat, rdc; exp_t x;
        exp_q.push_back('{word: 32'h0, err: 1'b1, lat: 1});
        do_load(32'h100, 3'd6, 0, 0, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat || rdc != 0 || tail !== 1'b1) begin
            errors++;
            $display("FAIL illegal_type: word=%h err=%b lat=%0d rd_cycles=%0d tail=%b, need %h %b %0d 0 1",
                     w, e, lat, rdc, tail, x.word, x.err, x.lat);
        end
`ifdef MISALIGN_TRAP_EN
        exp_q.push_back('{word: 32'h0, err: 1'b1, lat: 1});
`else
        exp_q.push_back('{word: 32'h80FF7F01, err: 1'b0, lat: 2});
`endif
        do_load(32'h101, T_LW, 0, 0, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat || (x.err == 1'b0 && ma !== 32'h100)) begin
            errors++;
            $display("FAIL misaligned_lw: word=%h err=%b lat=%0d addr=%h, need %h %b %0d",
                     w, e, lat, ma, x.word, x.err, x.lat);
        end
    endtask

    task automatic test_reset_mid_read();
        logic bad = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h204; req_type = T_LW;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, mem_rd, mem_addr, done_valid, word, err} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_read: rdy=%b rd=%b addr=%h dv=%b word=%h err=%b, need 1 0 0 0 0 0",
                     req_ready, mem_rd, mem_addr, done_valid, word, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_valid || mem_rd || !req_ready || word != 32'h0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_after_reset: activity seen=%b, need 0", bad);
        end
    endtask

    task automatic test_clk_en();
        logic [31:0] w, ma; logic e, rdy, tail; int lat, rdc; exp_t x;
        // Stall of 5 cycles with mem_ack held high: ack ignored, timeout pushed out by 5.
        exp_q.push_back('{word: 32'h0, err: 1'b1, lat: 22});
        do_load(32'h100, T_LB, NO_ACK, 3, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat) begin
            errors++;
            $display("FAIL clk_en_stall: word=%h err=%b lat=%0d, need %h %b %0d", w, e, lat, x.word, x.err, x.lat);
        end
        exp_q.push_back('{word: 32'h0000007F, err: 1'b0, lat: 9});
        do_load(32'h101, T_LBU, 7, 2, w, e, lat, rdc, ma, rdy, tail);
        x = exp_q.pop_front();
        checks++;
        if (w !== x.word || e !== x.err || lat != x.lat) begin
            errors++;
            $display("FAIL clk_en_then_ack: word=%h err=%b lat=%0d, need %h %b %0d", w, e, lat, x.word, x.err, x.lat);
        end
    endtask

    initial begin
        test_reset();
        test_extract();
        test_random();
        test_delayed_ack();
        test_back_to_back();
        test_timeout();
        test_illegal_misalign();
        test_reset_mid_read();
        test_clk_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
